// File: rtl/fifo_pkg.sv
// Shared types for the FIFO drain path.
// Holds the packer state encoding and the lane-count width helper.
package fifo_pkg;

    typedef enum logic {
        PK_FILL,
        PK_HOLD
    } pack_state_e;

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drain stage: pops FIFO entries and packs PACK_RATIO lanes per output word.
// Words are held on a valid/ready port; flush emits a partially filled word.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            fifo_head,
    input  logic                             fifo_empty,
    output logic                             fifo_pop,
    input  logic                             flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [cnt_width(PACK_RATIO)-1:0] out_count,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int CW = cnt_width(PACK_RATIO);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [DATA_WIDTH-1:0] lane_t;

    pack_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    cnt_t        count_q, count_d;
    cnt_t        base;
    cnt_t        cnt_next;
    lane_t       lanes_q [PACK_RATIO];
    lane_t       lanes_d [PACK_RATIO];
    logic        handshake;
    logic        advance;

    always_comb begin
        handshake = (state_q == PK_HOLD) && out_ready;
        advance   = (state_q == PK_FILL) || out_ready;
        fifo_pop  = rst_n && !fifo_empty && advance;
        base      = (state_q == PK_FILL) ? cnt_q : '0;
        cnt_next  = base + cnt_t'(fifo_pop);
    end

    // A held word blocks everything, including flush, until it is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        lanes_d = lanes_q;
        if (advance) begin
            if (handshake) begin
                for (int i = 0; i < PACK_RATIO; i++) begin
                    lanes_d[i] = '0;
                end
            end
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (fifo_pop && (base == cnt_t'(i))) begin
                    lanes_d[i] = fifo_head;
                end
            end
            cnt_d = cnt_next;
            if ((cnt_next == cnt_t'(PACK_RATIO)) ||
                (flush && (cnt_next != '0))) begin
                state_d = PK_HOLD;
                count_d = cnt_next;
            end else begin
                state_d = PK_FILL;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PK_FILL;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                lanes_q[i] <= lanes_d[i];
            end
        end
    end

    // Partial lanes are hidden until the word is presented.
    always_comb begin
        out_valid = (state_q == PK_HOLD);
        out_count = count_q;
        out_data  = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = out_valid ? lanes_q[i] : '0;
        end
    end

endmodule
